// File: rtl/call_stack_pkg.sv
// call_stack_pkg
//   Shared definitions for the subroutine call stack: default widths and
//   depth that match the control unit's PC / code-memory address, and the
//   per-cycle operation decode formed from {push, pop}.
package call_stack_pkg;

    localparam int CS_PC_W    = 9;
    localparam int CS_FLAGS_W = 4;
    localparam int CS_DEPTH   = 16;

    // Per-cycle operation, encoded directly as {push, pop}.
    typedef enum logic [1:0] {
        OP_NONE    = 2'b00,
        OP_POP     = 2'b01,
        OP_PUSH    = 2'b10,
        OP_REPLACE = 2'b11
    } stack_op_e;

endpackage

// File: rtl/stack_mem.sv
// stack_mem
//   DEPTH x WIDTH register file backing the call stack. One synchronous
//   write port and one asynchronous read port. Contents are never reset.
// Ports
//   clk    in   system clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data (combinational from raddr)
module stack_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 13
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/call_stack.sv
// call_stack
//   Hardware LIFO for subroutine call/return. A push saves {in_pc, in_flags};
//   a pop returns the top entry on out_pc/out_flags one cycle after the pop
//   edge. Push and pop together replace the top entry while returning the old
//   one. The stack pointer saturates at 0 and DEPTH; any overflow or
//   underflow attempt sets the sticky out_error, cleared only by reset.
// Ports
//   clk, reset            clock, synchronous active-high reset
//   in_push_en/in_pop_en  operation request for this cycle
//   in_pc/in_flags        entry to save
//   out_pc/out_flags      last popped entry (registered)
//   out_count             occupancy, out_empty/out_full derived from it
//   out_error             sticky overflow/underflow flag
// Configuration
//   CALL_STACK_PEEK_EN    adds out_top_pc/out_top_flags, a combinational view
//                         of the current top entry (0 when empty).
module call_stack
    import call_stack_pkg::*;
#(
    parameter int DEPTH   = CS_DEPTH,
    parameter int PC_W    = CS_PC_W,
    parameter int FLAGS_W = CS_FLAGS_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_push_en,
    input  logic                       in_pop_en,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [FLAGS_W-1:0]         in_flags,
    output logic [PC_W-1:0]            out_pc,
    output logic [FLAGS_W-1:0]         out_flags,
    output logic [$clog2(DEPTH):0]     out_count,
    output logic                       out_empty,
    output logic                       out_full,
    output logic                       out_error
`ifdef CALL_STACK_PEEK_EN
    ,
    output logic [PC_W-1:0]            out_top_pc,
    output logic [FLAGS_W-1:0]         out_top_flags
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = PC_W + FLAGS_W;

    logic [CW-1:0]      sp_q, sp_d;
    logic [PC_W-1:0]    out_pc_q, out_pc_d;
    logic [FLAGS_W-1:0] out_flags_q, out_flags_d;
    logic               error_q, error_d;

    logic               mem_we;
    logic [AW-1:0]      mem_waddr;
    logic [AW-1:0]      top_addr;
    logic [EW-1:0]      mem_rdata;
    logic               is_empty, is_full;
    stack_op_e          op;

    assign is_empty = (sp_q == '0);
    assign is_full  = (sp_q == CW'(DEPTH));
    // At sp == DEPTH the low bits wrap to 0, so subtracting one still lands
    // on the last entry.
    assign top_addr = sp_q[AW-1:0] - AW'(1);
    assign op       = stack_op_e'({in_push_en, in_pop_en});

    always_comb begin
        sp_d        = sp_q;
        out_pc_d    = out_pc_q;
        out_flags_d = out_flags_q;
        error_d     = error_q;
        mem_we      = 1'b0;
        mem_waddr   = sp_q[AW-1:0];

        case (op)
            OP_PUSH: begin
                if (is_full) begin
                    error_d = 1'b1;
                end else begin
                    mem_we = 1'b1;
                    sp_d   = sp_q + CW'(1);
                end
            end
            OP_POP: begin
                if (is_empty) begin
                    error_d = 1'b1;
                end else begin
                    {out_pc_d, out_flags_d} = mem_rdata;
                    sp_d = sp_q - CW'(1);
                end
            end
            OP_REPLACE: begin
                mem_we = 1'b1;
                if (is_empty) begin
                    // Nothing to return: the push still happens, the pop is an underflow.
                    error_d = 1'b1;
                    sp_d    = sp_q + CW'(1);
                end else begin
                    {out_pc_d, out_flags_d} = mem_rdata;
                    mem_waddr = top_addr;
                end
            end
            default: ;
        endcase

        // Reset wins over any operation, including the RAM write.
        if (reset) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q        <= '0;
            out_pc_q    <= '0;
            out_flags_q <= '0;
            error_q     <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            out_pc_q    <= out_pc_d;
            out_flags_q <= out_flags_d;
            error_q     <= error_d;
        end
    end

    stack_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_stack_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata ({in_pc, in_flags}),
        .raddr (top_addr),
        .rdata (mem_rdata)
    );

    assign out_pc    = out_pc_q;
    assign out_flags = out_flags_q;
    assign out_count = sp_q;
    assign out_empty = is_empty;
    assign out_full  = is_full;
    assign out_error = error_q;

`ifdef CALL_STACK_PEEK_EN
    assign out_top_pc    = is_empty ? '0 : mem_rdata[EW-1:FLAGS_W];
    assign out_top_flags = is_empty ? '0 : mem_rdata[FLAGS_W-1:0];
`endif

endmodule

// File: tb/tb_call_stack.sv
module tb_call_stack;

    localparam int DEPTH   = 16;
    localparam int PC_W    = 9;
    localparam int FLAGS_W = 4;
    localparam int CW      = 5;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_push_en, in_pop_en;
    logic [PC_W-1:0]    in_pc;
    logic [FLAGS_W-1:0] in_flags;
    logic [PC_W-1:0]    out_pc;
    logic [FLAGS_W-1:0] out_flags;
    logic [CW-1:0]      out_count;
    logic               out_empty, out_full, out_error;
`ifdef CALL_STACK_PEEK_EN
    logic [PC_W-1:0]    out_top_pc;
    logic [FLAGS_W-1:0] out_top_flags;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    call_stack dut (
        .clk        (clk),
        .reset      (reset),
        .in_push_en (in_push_en),
        .in_pop_en  (in_pop_en),
        .in_pc      (in_pc),
        .in_flags   (in_flags),
        .out_pc     (out_pc),
        .out_flags  (out_flags),
        .out_count  (out_count),
        .out_empty  (out_empty),
        .out_full   (out_full),
        .out_error  (out_error)
`ifdef CALL_STACK_PEEK_EN
        ,
        .out_top_pc    (out_top_pc),
        .out_top_flags (out_top_flags)
`endif
    );

    // Reference model: a plain queue of {pc, flags} entries.
    logic [PC_W+FLAGS_W-1:0] mq[$];
    logic [PC_W-1:0]         m_pc;
    logic [FLAGS_W-1:0]      m_fl;
    logic                    m_err;

    task automatic model_step(input logic rst, input logic push, input logic pop,
                              input logic [PC_W-1:0] pc, input logic [FLAGS_W-1:0] fl);
        if (rst) begin
            mq.delete(); m_pc = '0; m_fl = '0; m_err = 1'b0;
        end else if (push && pop) begin
            if (mq.size() == 0) begin
                mq.push_back({pc, fl}); m_err = 1'b1;
            end else begin
                {m_pc, m_fl} = mq.pop_back();
                mq.push_back({pc, fl});
            end
        end else if (push) begin
            if (mq.size() == DEPTH) m_err = 1'b1;
            else mq.push_back({pc, fl});
        end else if (pop) begin
            if (mq.size() == 0) m_err = 1'b1;
            else {m_pc, m_fl} = mq.pop_back();
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, clock, then sample 1 time unit after the edge.
    task automatic cyc(input logic rst, input logic push, input logic pop,
                       input logic [PC_W-1:0] pc, input logic [FLAGS_W-1:0] fl);
        reset = rst; in_push_en = push; in_pop_en = pop; in_pc = pc; in_flags = fl;
        @(posedge clk);
        #1;
        reset = 1'b0; in_push_en = 1'b0; in_pop_en = 1'b0;
    endtask

    function automatic logic [31:0] dut_state();
        return {11'd0, out_pc, out_flags, out_count, out_empty, out_full, out_error};
    endfunction

    function automatic logic [31:0] model_state();
        logic [CW-1:0] n;
        n = CW'(mq.size());
        return {11'd0, m_pc, m_fl, n, (mq.size() == 0), (mq.size() == DEPTH), m_err};
    endfunction

    typedef struct {
        logic               push, pop;
        logic [PC_W-1:0]    pc;
        logic [FLAGS_W-1:0] fl;
        logic [PC_W-1:0]    e_pc;
        logic [FLAGS_W-1:0] e_fl;
        logic [CW-1:0]      e_cnt;
        logic               e_empty, e_full, e_err;
    } vec_t;

    function automatic vec_t mk(logic push, logic pop, logic [PC_W-1:0] pc, logic [FLAGS_W-1:0] fl,
                                logic [PC_W-1:0] e_pc, logic [FLAGS_W-1:0] e_fl, logic [CW-1:0] e_cnt,
                                logic e_empty, logic e_full, logic e_err);
        vec_t v;
        v.push = push; v.pop = pop; v.pc = pc; v.fl = fl;
        v.e_pc = e_pc; v.e_fl = e_fl; v.e_cnt = e_cnt;
        v.e_empty = e_empty; v.e_full = e_full; v.e_err = e_err;
        return v;
    endfunction

    vec_t tbl[17];

    initial begin
        tbl[0]  = mk(1, 0, 9'h1E1, 4'b1001, 9'h000, 4'h0, 1, 0, 0, 0);
        tbl[1]  = mk(0, 1, 9'h000, 4'h0,    9'h1E1, 4'h9, 0, 1, 0, 0);
        tbl[2]  = mk(1, 0, 9'd10,  4'd1,    9'h1E1, 4'h9, 1, 0, 0, 0);
        tbl[3]  = mk(1, 0, 9'd20,  4'd2,    9'h1E1, 4'h9, 2, 0, 0, 0);
        tbl[4]  = mk(1, 0, 9'd30,  4'd3,    9'h1E1, 4'h9, 3, 0, 0, 0);
        tbl[5]  = mk(0, 1, 9'h000, 4'h0,    9'd30,  4'd3, 2, 0, 0, 0);
        tbl[6]  = mk(0, 1, 9'h000, 4'h0,    9'd20,  4'd2, 1, 0, 0, 0);
        tbl[7]  = mk(0, 1, 9'h000, 4'h0,    9'd10,  4'd1, 0, 1, 0, 0);
        tbl[8]  = mk(1, 0, 9'd5,   4'h0,    9'd10,  4'd1, 1, 0, 0, 0);
        tbl[9]  = mk(1, 0, 9'd6,   4'h0,    9'd10,  4'd1, 2, 0, 0, 0);
        tbl[10] = mk(1, 1, 9'd7,   4'h0,    9'd6,   4'h0, 2, 0, 0, 0);
        tbl[11] = mk(0, 1, 9'h000, 4'h0,    9'd7,   4'h0, 1, 0, 0, 0);
        tbl[12] = mk(0, 1, 9'h000, 4'h0,    9'd5,   4'h0, 0, 1, 0, 0);
        tbl[13] = mk(0, 0, 9'h000, 4'h0,    9'd5,   4'h0, 0, 1, 0, 0);
        tbl[14] = mk(0, 1, 9'h000, 4'h0,    9'd5,   4'h0, 0, 1, 0, 1);
        tbl[15] = mk(1, 1, 9'h0AA, 4'hF,    9'd5,   4'h0, 1, 0, 0, 1);
        tbl[16] = mk(0, 1, 9'h000, 4'h0,    9'h0AA, 4'hF, 0, 1, 0, 1);

        reset = 1'b1; in_push_en = 1'b0; in_pop_en = 1'b0; in_pc = '0; in_flags = '0;
        repeat (2) @(posedge clk);
        cyc(1, 0, 0, '0, '0);
        chk("reset_state", dut_state(), {11'd0, 9'd0, 4'd0, 5'd0, 1'b1, 1'b0, 1'b0});

        // Directed table: basic push/pop, LIFO order, replace, empty errors.
        for (int i = 0; i < 17; i++) begin
            cyc(0, tbl[i].push, tbl[i].pop, tbl[i].pc, tbl[i].fl);
            chk($sformatf("tbl[%0d]", i), dut_state(),
                {11'd0, tbl[i].e_pc, tbl[i].e_fl, tbl[i].e_cnt, tbl[i].e_empty, tbl[i].e_full, tbl[i].e_err});
        end

        // Fill to capacity, then overflow with 1FF; drain and check order.
        cyc(1, 0, 0, '0, '0);
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0, PC_W'(i), FLAGS_W'(i));
        chk("full_before_ovf", {out_full, out_count, out_error}, {1'b1, 5'd16, 1'b0});
        cyc(0, 1, 0, 9'h1FF, 4'hF);
        chk("overflow", {out_full, out_count, out_error}, {1'b1, 5'd16, 1'b1});
        for (int i = DEPTH - 1; i >= 0; i--) begin
            cyc(0, 0, 1, '0, '0);
            chk($sformatf("drain_%0d", i), {out_pc, out_flags}, {PC_W'(i), FLAGS_W'(i)});
        end
        chk("drained_empty", {out_empty, out_count}, {1'b1, 5'd0});

        // Replace while full is legal and must not flag an error.
        cyc(1, 0, 0, '0, '0);
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0, PC_W'(i + 100), 4'h2);
        cyc(0, 1, 1, 9'h055, 4'h5);
        chk("replace_full", dut_state(), {11'd0, 9'd115, 4'h2, 5'd16, 1'b0, 1'b1, 1'b0});
        cyc(0, 0, 1, '0, '0);
        chk("replace_full_pop", {out_pc, out_flags}, {9'h055, 4'h5});

        // Reset together with a push clears everything, including a sticky error.
        cyc(1, 0, 0, '0, '0);
        cyc(0, 0, 1, '0, '0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, PC_W'(i + 40), 4'hA);
        cyc(0, 0, 1, '0, '0);
        chk("pre_reset", {out_pc, out_error, out_count}, {9'd43, 1'b1, 5'd3});
        cyc(1, 1, 0, 9'h077, 4'h7);
        chk("reset_with_push", dut_state(), {11'd0, 9'd0, 4'd0, 5'd0, 1'b1, 1'b0, 1'b0});
`ifdef CALL_STACK_PEEK_EN
        chk("peek_after_reset", {out_top_pc, out_top_flags}, '0);
`endif

        // Randomised traffic against the queue model, with push/pop bias
        // changing per phase so both full and empty are reached.
        cyc(1, 0, 0, '0, '0);
        model_step(1, 0, 0, '0, '0);
        for (int n = 0; n < 3000; n++) begin
            logic rst, push, pop;
            logic [PC_W-1:0] pc;
            logic [FLAGS_W-1:0] fl;
            int bias;
            bias = ((n / 150) % 2 == 0) ? 70 : 30;
            rst  = ($urandom_range(0, 199) == 0);
            push = ($urandom_range(0, 99) < bias);
            pop  = ($urandom_range(0, 99) < (100 - bias));
            pc   = PC_W'($urandom);
            fl   = FLAGS_W'($urandom);
            cyc(rst, push, pop, pc, fl);
            model_step(rst, push, pop, pc, fl);
            chk($sformatf("rand_%0d", n), dut_state(), model_state());
`ifdef CALL_STACK_PEEK_EN
            chk($sformatf("rand_peek_%0d", n), {23'd0, out_top_pc, out_top_flags},
                {23'd0, (mq.size() == 0) ? 13'd0 : mq[mq.size() - 1]});
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
